// File: rtl/qm_muldiv_sequencer_pkg.sv
// Shared op codes and sign-fix bookkeeping for the iterative mul/div sequencer.
package qm_muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic div0;
  } md_fix_t;

  function automatic logic is_div_op(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/qm_muldiv_sequencer_step.sv
// One combinational iteration: add-shift for multiply, restoring trial-subtract for divide.
module qm_muldiv_sequencer_step
  import qm_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH:0]   hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH:0]   hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_borrow;

  // Multiply: lo holds the unconsumed multiplier bits, hi the running partial product.
  assign mul_sum = hi_i + {1'b0, (lo_i[0] ? opnd_i : '0)};

  // Divide: lo shifts dividend bits out the top and quotient bits in at the bottom.
  assign div_shift  = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
  assign div_trial  = {1'b0, div_shift} - {2'b00, opnd_i};
  assign div_borrow = div_trial[WIDTH+1];

  always_comb begin
    hi_o = {1'b0, mul_sum[WIDTH:1]};
    lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
    if (is_div_i) begin
      hi_o = div_borrow ? div_shift : div_trial[WIDTH:0];
      lo_o = {lo_i[WIDTH-2:0], ~div_borrow};
    end
  end

endmodule

// File: rtl/qm_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall generation.
module qm_muldiv_sequencer
  import qm_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [WIDTH-1:0] i_OperandA,
  input  logic [WIDTH-1:0] i_OperandB,
  input  logic             i_Abort,
  input  logic             i_HiLoRead,
  input  logic             i_MtHi,
  input  logic             i_MtLo,
  input  logic [WIDTH-1:0] i_MtData,
  output logic             o_Busy,
  output logic             o_Stall,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Hi,
  output logic [WIDTH-1:0] o_Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  // state  | meaning
  // S_IDLE | waiting for start; MTHI/MTLO accepted
  // S_PREP | magnitudes and result signs derived from latched operands
  // S_RUN  | one mul/div iteration per cycle, cnt_q counts WIDTH-1..0
  // S_FIX  | sign correction applied, HI/LO committed on exit
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PREP = 2'b01,
    S_RUN  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  state_e           state_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  md_fix_t          fix_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             sign_a;
  logic             sign_b;
  logic             op_is_div;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  md_fix_t          fix_d;
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0] res_hi_d;
  logic [WIDTH-1:0] res_lo_d;

  assign op_is_div = is_div_op(op_q);
  assign sign_a    = is_signed_op(op_q) & a_q[WIDTH-1];
  assign sign_b    = is_signed_op(op_q) & b_q[WIDTH-1];
  assign mag_a_d   = sign_a ? -a_q : a_q;
  assign mag_b_d   = sign_b ? -b_q : b_q;

  always_comb begin
    fix_d       = '0;
    fix_d.neg_q = sign_a ^ sign_b;
    fix_d.neg_r = sign_a;
    fix_d.div0  = op_is_div && (b_q == '0);
  end

  qm_muldiv_sequencer_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (op_is_div),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  assign prod_d = fix_q.neg_q ? -{acc_hi_q[WIDTH-1:0], acc_lo_q}
                              :  {acc_hi_q[WIDTH-1:0], acc_lo_q};

  // Divide-by-zero bypasses sign fix-up and returns the raw dividend in HI.
  always_comb begin
    res_hi_d = prod_d[2*WIDTH-1:WIDTH];
    res_lo_d = prod_d[WIDTH-1:0];
    if (op_is_div) begin
      if (fix_q.div0) begin
        res_hi_d = a_q;
        res_lo_d = '1;
      end else begin
        res_lo_d = fix_q.neg_q ? -acc_lo_q : acc_lo_q;
        res_hi_d = fix_q.neg_r ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      fix_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_Abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_Start && !i_Abort) begin
              op_q    <= md_op_e'(i_Op);
              a_q     <= i_OperandA;
              b_q     <= i_OperandB;
              state_q <= S_PREP;
            end else begin
              if (i_MtHi) hi_q <= i_MtData;
              if (i_MtLo) lo_q <= i_MtData;
            end
          end
          S_PREP: begin
            fix_q    <= fix_d;
            opnd_q   <= op_is_div ? mag_b_d : mag_a_d;
            acc_hi_q <= '0;
            acc_lo_q <= op_is_div ? mag_a_d : mag_b_d;
            cnt_q    <= CNT_W'(WIDTH - 1);
            state_q  <= S_RUN;
          end
          S_RUN: begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (cnt_q == '0) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_FIX: begin
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_Busy  = (state_q != S_IDLE);
  assign o_Stall = o_Busy & (i_Start | i_HiLoRead | i_MtHi | i_MtLo);
  assign o_Done  = done_q;
  assign o_Hi    = hi_q;
  assign o_Lo    = lo_q;

endmodule

// File: tb/tb_qm_muldiv_sequencer.sv
// Scoreboard bench: expected HI/LO from plain-arithmetic reference, compared on o_Done.
module tb_qm_muldiv_sequencer;

  localparam int W = 32;

  logic         i_Clock = 1'b0;
  logic         i_Reset_n = 1'b0;
  logic         i_Start = 1'b0;
  logic [1:0]   i_Op = 2'b00;
  logic [W-1:0] i_OperandA = '0;
  logic [W-1:0] i_OperandB = '0;
  logic         i_Abort = 1'b0;
  logic         i_HiLoRead = 1'b0;
  logic         i_MtHi = 1'b0;
  logic         i_MtLo = 1'b0;
  logic [W-1:0] i_MtData = '0;
  logic         o_Busy;
  logic         o_Stall;
  logic         o_Done;
  logic [W-1:0] o_Hi;
  logic [W-1:0] o_Lo;

  qm_muldiv_sequencer #(.WIDTH(W)) dut (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .i_Start    (i_Start),
    .i_Op       (i_Op),
    .i_OperandA (i_OperandA),
    .i_OperandB (i_OperandB),
    .i_Abort    (i_Abort),
    .i_HiLoRead (i_HiLoRead),
    .i_MtHi     (i_MtHi),
    .i_MtLo     (i_MtLo),
    .i_MtData   (i_MtData),
    .o_Busy     (o_Busy),
    .o_Stall    (o_Stall),
    .o_Done     (o_Done),
    .o_Hi       (o_Hi),
    .o_Lo       (o_Lo)
  );

  always #5 i_Clock = ~i_Clock;

  logic [63:0]  sb_q[$];
  logic [63:0]  mon_e;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'b00: begin q = sa * sb; p = q; end
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, a};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  always @(negedge i_Clock) begin
    if (i_Reset_n && o_Done) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {63'b0, o_Done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", {o_Hi, o_Lo}, mon_e);
        exp_hi = mon_e[63:32];
        exp_lo = mon_e[31:0];
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push);
    @(negedge i_Clock);
    i_Op = op;
    i_OperandA = a;
    i_OperandB = b;
    i_Start = 1'b1;
    if (push) sb_q.push_back(ref_result(op, a, b));
    @(negedge i_Clock);
    i_Start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    int busy;
    start_op(op, a, b, 1'b1);
    cyc = 1;
    busy = 0;
    for (int k = 0; k < 100; k++) begin
      if (o_Done) break;
      if (o_Busy) busy++;
      @(negedge i_Clock);
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(W + 3));
    chk("busy_cycles", 64'(busy), 64'(W + 2));
  endtask

  task automatic mt_write(input bit hi, input bit lo, input logic [W-1:0] data);
    @(negedge i_Clock);
    i_MtHi = hi;
    i_MtLo = lo;
    i_MtData = data;
    @(negedge i_Clock);
    i_MtHi = 1'b0;
    i_MtLo = 1'b0;
    if (hi) exp_hi = data;
    if (lo) exp_lo = data;
    chk("mt_hi", {32'b0, o_Hi}, {32'b0, exp_hi});
    chk("mt_lo", {32'b0, o_Lo}, {32'b0, exp_lo});
    chk("mt_no_done", {63'b0, o_Done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bit           stall_ok;

    i_HiLoRead = 1'b1;
    #23;
    chk("rst_busy", {63'b0, o_Busy}, 64'd0);
    chk("rst_done", {63'b0, o_Done}, 64'd0);
    chk("rst_stall", {63'b0, o_Stall}, 64'd0);
    chk("rst_hilo", {o_Hi, o_Lo}, 64'd0);
    i_HiLoRead = 1'b0;
    @(negedge i_Clock);
    i_Reset_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {o_Hi, o_Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg", {o_Hi, o_Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {o_Hi, o_Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd2);
    chk("divu", {o_Hi, o_Lo}, 64'h0000_0001_0000_0003);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {o_Hi, o_Lo}, 64'h0000_0000_8000_0000);
    run_op(2'b11, 32'h0000_1234, 32'd0);
    chk("divu_zero", {o_Hi, o_Lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0);
    chk("div_zero_signed", {o_Hi, o_Lo}, 64'hFFFF_FFF0_FFFF_FFFF);

    mt_write(1'b1, 1'b1, 32'h1357_9BDF);
    mt_write(1'b1, 1'b0, 32'h0BAD_F00D);
    mt_write(1'b0, 1'b1, 32'h0000_C0DE);

    // Busy with HI/LO read, MTLO and a second start all pending.
    start_op(2'b00, 32'd12345, 32'hFFFF_FF00, 1'b1);
    repeat (9) @(negedge i_Clock);
    i_HiLoRead = 1'b1;
    i_Start = 1'b1;
    i_Op = 2'b11;
    i_OperandA = 32'd99;
    i_OperandB = 32'd5;
    i_MtLo = 1'b1;
    i_MtData = 32'hDEAD_BEEF;
    stall_ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!o_Busy) begin
        stall_ok = 1'b1;
        break;
      end
      chk("stall_busy", {63'b0, o_Stall}, 64'd1);
      @(negedge i_Clock);
    end
    i_Start = 1'b0;
    i_MtLo = 1'b0;
    #1;
    chk("stall_idle", {63'b0, o_Stall}, 64'd0);
    chk("stall_loop_end", {63'b0, stall_ok}, 64'd1);
    i_HiLoRead = 1'b0;
    @(negedge i_Clock);
    chk("second_start_dropped", {63'b0, o_Busy}, 64'd0);
    chk("stall_hilo_first", {o_Hi, o_Lo}, ref_result(2'b00, 32'd12345, 32'hFFFF_FF00));

    // Abort at RUN iteration 5.
    mt_write(1'b1, 1'b0, 32'h0000_AAAA);
    mt_write(1'b0, 1'b1, 32'h0000_5555);
    start_op(2'b01, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    repeat (6) @(negedge i_Clock);
    i_Abort = 1'b1;
    @(negedge i_Clock);
    i_Abort = 1'b0;
    chk("abort_busy", {63'b0, o_Busy}, 64'd0);
    chk("abort_done", {63'b0, o_Done}, 64'd0);
    chk("abort_hilo", {o_Hi, o_Lo}, 64'h0000_AAAA_0000_5555);
    repeat (40) @(negedge i_Clock);
    chk("abort_hilo_later", {o_Hi, o_Lo}, 64'h0000_AAAA_0000_5555);

    // Abort in FIX suppresses the commit.
    start_op(2'b11, 32'd1000, 32'd3, 1'b0);
    repeat (W + 1) @(negedge i_Clock);
    chk("fix_still_busy", {63'b0, o_Busy}, 64'd1);
    i_Abort = 1'b1;
    @(negedge i_Clock);
    i_Abort = 1'b0;
    chk("fix_abort_busy", {63'b0, o_Busy}, 64'd0);
    chk("fix_abort_done", {63'b0, o_Done}, 64'd0);
    chk("fix_abort_hilo", {o_Hi, o_Lo}, 64'h0000_AAAA_0000_5555);

    // Abort wins over a same-cycle start.
    @(negedge i_Clock);
    i_Start = 1'b1;
    i_Abort = 1'b1;
    @(negedge i_Clock);
    i_Start = 1'b0;
    i_Abort = 1'b0;
    chk("abort_beats_start", {63'b0, o_Busy}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb);
    end

    // Async reset between edges mid-RUN.
    mt_write(1'b1, 1'b1, 32'h1111_1111);
    start_op(2'b10, 32'd5000, 32'd7, 1'b0);
    repeat (12) @(negedge i_Clock);
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, o_Busy}, 64'd0);
    chk("async_rst_hilo", {o_Hi, o_Lo}, 64'd0);
    chk("async_rst_done", {63'b0, o_Done}, 64'd0);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    repeat (40) @(negedge i_Clock);
    chk("post_rst_hilo", {o_Hi, o_Lo}, 64'd0);

    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000);
    repeat (3) @(negedge i_Clock);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
